// File: rtl/maxnet_iteration_controller.sv
// +--------------------------------------------------------------------------+
// | maxnet_iteration_controller: Maxnet winner-take-all iteration sequencer.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module maxnet_iteration_controller #(
  parameter int XLEN       = 32,
  parameter int PU_LATENCY = 2,
  parameter int MAX_ITER   = 255,
  parameter int ITER_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [XLEN-1:0]   data_in0,
  input  logic [XLEN-1:0]   data_in1,
  input  logic [XLEN-1:0]   data_in2,
  input  logic [XLEN-1:0]   data_in3,
  input  logic [XLEN-1:0]   pu_result0,
  input  logic [XLEN-1:0]   pu_result1,
  input  logic [XLEN-1:0]   pu_result2,
  input  logic [XLEN-1:0]   pu_result3,
  output logic [XLEN-1:0]   pu_num0,
  output logic [XLEN-1:0]   pu_num1,
  output logic [XLEN-1:0]   pu_num2,
  output logic [XLEN-1:0]   pu_num3,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner_idx,
  output logic [XLEN-1:0]   winner_val,
  output logic              no_winner,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam int WAIT_W = (PU_LATENCY > 1) ? $clog2(PU_LATENCY) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     v_q [4];
  logic [XLEN-1:0]     v_d [4];
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          widx_q, widx_d;
  logic [XLEN-1:0]     wval_q, wval_d;
  logic                nowin_q, nowin_d;
  logic                tmo_q, tmo_d;

  logic [XLEN-1:0]     din_w [4];
  logic [XLEN-1:0]     res_w [4];
  logic [2:0]          nz_cnt;
  logic [1:0]          nz_low;

  // Negative values and both signed zeros collapse to +0.
  function automatic logic [XLEN-1:0] relu(input logic [XLEN-1:0] x);
    return (x[XLEN-1] || (x[XLEN-2:0] == '0)) ? '0 : x;
  endfunction

  assign din_w[0] = data_in0;
  assign din_w[1] = data_in1;
  assign din_w[2] = data_in2;
  assign din_w[3] = data_in3;
  assign res_w[0] = pu_result0;
  assign res_w[1] = pu_result1;
  assign res_w[2] = pu_result2;
  assign res_w[3] = pu_result3;

  // Descending scan leaves nz_low at the lowest non-zero index.
  always_comb begin
    nz_cnt = '0;
    nz_low = '0;
    for (int k = 3; k >= 0; k--) begin
      if (v_q[k][XLEN-2:0] != '0) begin
        nz_cnt = nz_cnt + 3'd1;
        nz_low = 2'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    iter_d  = iter_q;
    wcnt_d  = wcnt_q;
    widx_d  = widx_q;
    wval_d  = wval_q;
    nowin_d = nowin_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          for (int k = 0; k < 4; k++) v_d[k] = relu(din_w[k]);
          iter_d  = '0;
          wcnt_d  = '0;
          widx_d  = '0;
          wval_d  = '0;
          nowin_d = 1'b0;
          tmo_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == WAIT_W'(PU_LATENCY - 1)) begin
          wcnt_d  = '0;
          state_d = ST_CAPTURE;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      ST_CAPTURE: begin
        for (int k = 0; k < 4; k++) v_d[k] = relu(res_w[k]);
        iter_d  = iter_q + ITER_W'(1);
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (nz_cnt == 3'd0) begin
          nowin_d = 1'b1;
          widx_d  = '0;
          wval_d  = '0;
          state_d = ST_DONE;
        end else if (nz_cnt == 3'd1) begin
          widx_d  = nz_low;
          wval_d  = v_q[nz_low];
          state_d = ST_DONE;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          tmo_d   = 1'b1;
          widx_d  = nz_low;
          wval_d  = v_q[nz_low];
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_WAIT) || (state_d == ST_CAPTURE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < 4; k++) v_q[k] <= '0;
      iter_q  <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      widx_q  <= '0;
      wval_q  <= '0;
      nowin_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < 4; k++) v_q[k] <= v_d[k];
      iter_q  <= iter_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      widx_q  <= widx_d;
      wval_q  <= wval_d;
      nowin_q <= nowin_d;
      tmo_q   <= tmo_d;
    end
  end

  assign pu_num0    = v_q[0];
  assign pu_num1    = v_q[1];
  assign pu_num2    = v_q[2];
  assign pu_num3    = v_q[3];
  assign busy       = busy_q;
  assign done       = done_q;
  assign winner_idx = widx_q;
  assign winner_val = wval_q;
  assign no_winner  = nowin_q;
  assign timeout    = tmo_q;
  assign iter_count = iter_q;

endmodule

`default_nettype wire

// File: tb/tb_maxnet_iteration_controller.sv
// +--------------------------------------------------------------------------+
// | tb_maxnet_iteration_controller: bench with pipelined float PU models.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_maxnet_iteration_controller;

  localparam int L  = 2;
  localparam int MI = 8;

  typedef logic [3:0][31:0] vec4_t;

  typedef struct packed {
    vec4_t       d;
    int          iter;
    int          idx;
    logic [31:0] val;
    int          tol;
    bit          nw;
    bit          to;
    int          lat;
  } tv_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  vec4_t       din;
  vec4_t       pres;
  vec4_t       pnum;
  logic        busy, done, no_winner, timeout;
  logic [1:0]  winner_idx;
  logic [31:0] winner_val;
  logic [7:0]  iter_count;

  int n_chk  = 0;
  int n_fail = 0;

  maxnet_iteration_controller #(
    .XLEN(32), .PU_LATENCY(L), .MAX_ITER(MI), .ITER_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .pu_result0(pres[0]), .pu_result1(pres[1]), .pu_result2(pres[2]), .pu_result3(pres[3]),
    .pu_num0(pnum[0]), .pu_num1(pnum[1]), .pu_num2(pnum[2]), .pu_num3(pnum[3]),
    .busy(busy), .done(done), .winner_idx(winner_idx), .winner_val(winner_val),
    .no_winner(no_winner), .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Single <-> double conversion, round to nearest even, subnormals flushed.
  function automatic real f2r(input logic [31:0] b);
    if (b[30:23] == 8'd0) return 0.0;
    return $bitstoreal({b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    m = {1'b0, d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) m = m + 24'd1;
    if (m[23]) begin
      m = '0;
      e = e + 1;
    end
    if (e <= 0)   return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] relu(input logic [31:0] x);
    return (x[31] || x[30:0] == 31'd0) ? 32'd0 : x;
  endfunction

  // PU k: self weight 1.0, every other neuron weighted by -0.25.
  function automatic logic [31:0] pu_f(input int k, input vec4_t v);
    real s;
    s = f2r(v[k]);
    for (int j = 0; j < 4; j++) if (j != k) s = s - 0.25 * f2r(v[j]);
    return r2f(s);
  endfunction

  logic [31:0] pipe [4][L];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      pipe[k][0] <= pu_f(k, pnum);
      for (int s = 1; s < L; s++) pipe[k][s] <= pipe[k][s-1];
    end
  end
  always_comb for (int k = 0; k < 4; k++) pres[k] = pipe[k][L-1];

  // Whole-run reference: iterate the neuron vector until the stopping rule fires.
  task automatic model_run(input vec4_t d, output int n, output int idx,
                           output logic [31:0] val, output bit nw, output bit to);
    vec4_t v, nv;
    int    nzq[$];
    bit    fin;
    for (int k = 0; k < 4; k++) v[k] = relu(d[k]);
    n = 0; idx = 0; val = '0; nw = 0; to = 0; fin = 0;
    while (!fin) begin
      for (int k = 0; k < 4; k++) nv[k] = relu(pu_f(k, v));
      v = nv;
      n++;
      nzq.delete();
      for (int k = 0; k < 4; k++) if (v[k][30:0] != 31'd0) nzq.push_back(k);
      if (nzq.size() == 0) begin
        nw = 1; fin = 1;
      end else if (nzq.size() == 1 || n == MI) begin
        idx = nzq[0]; val = v[nzq[0]]; to = (nzq.size() > 1); fin = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input logic [31:0] act,
                         input logic [31:0] exp, input int tol);
    int diff;
    diff = int'(act) - int'(exp);
    if (diff < 0) diff = -diff;
    n_chk++;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h +/- %0d", name, act, exp, tol);
    end
  endtask

  // Start a run; optionally pulse a second start with junk data while busy.
  task automatic run(input vec4_t d, input bit disturb, output int lat);
    @(posedge clk); #1;
    din = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    for (int k = 0; k < 4; k++) chk($sformatf("load_num%0d", k), pnum[k], relu(d[k]));
    chk("busy_run", busy, 1);
    if (disturb) begin
      din = {4{32'h3F7FFFFF}}; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat++;
    end
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 2000) chk("done_wait_bound", 0, 1);
  endtask

  task automatic check_model(input string tag, input vec4_t d, input int lat);
    int          n, idx;
    logic [31:0] val;
    bit          nw, to;
    model_run(d, n, idx, val, nw, to);
    chk({tag, "_iter"}, iter_count, n);
    chk({tag, "_idx"}, winner_idx, idx);
    chk({tag, "_val"}, winner_val, val);
    chk({tag, "_nowin"}, no_winner, nw);
    chk({tag, "_tmo"}, timeout, to);
    chk({tag, "_lat"}, lat, 1 + n * (L + 2));
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    tv_t   tbl [4];
    vec4_t d;
    int    lat;

    tbl[0] = '{d: {32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD, 32'h3F000000},
               iter: 4, idx: 0, val: 32'h3E553333, tol: 2, nw: 0, to: 0, lat: 17};
    tbl[1] = '{d: {32'h0, 32'h0, 32'h0, 32'h3F333333},
               iter: 1, idx: 0, val: 32'h3F333333, tol: 0, nw: 0, to: 0, lat: 5};
    tbl[2] = '{d: {4{32'h3F000000}},
               iter: 8, idx: 0, val: 32'h37000000, tol: 0, nw: 0, to: 1, lat: 33};
    tbl[3] = '{d: {4{32'hBF800000}},
               iter: 1, idx: 0, val: 32'h0, tol: 0, nw: 1, to: 0, lat: 5};

    rst = 1'b0; start = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_num", pnum, '0);
    chk("rst_flags", {busy, done, no_winner, timeout}, 4'b0);
    chk("rst_win", {winner_idx, winner_val}, '0);
    chk("rst_iter", iter_count, 0);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run(tbl[i].d, 0, lat);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_done", i), done, 1);
      chk($sformatf("tbl%0d_iter", i), iter_count, tbl[i].iter);
      chk($sformatf("tbl%0d_idx", i), winner_idx, tbl[i].idx);
      chk_tol($sformatf("tbl%0d_val", i), winner_val, tbl[i].val, tbl[i].tol);
      chk($sformatf("tbl%0d_nowin", i), no_winner, tbl[i].nw);
      chk($sformatf("tbl%0d_tmo", i), timeout, tbl[i].to);
      check_model($sformatf("tbl%0d_m", i), tbl[i].d, lat);
    end

    // A start pulse while busy must change nothing.
    run(tbl[0].d, 1, lat);
    check_model("disturb", tbl[0].d, lat);

    // Restart from DONE with fresh data.
    @(posedge clk); #1;
    din = tbl[1].d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_done_low", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_flags", {no_winner, timeout}, 2'b0);
    lat = 1;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    check_model("restart", tbl[1].d, lat);

    // Reset asserted for one edge while in CAPTURE.
    @(posedge clk); #1;
    din = tbl[0].d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_num", pnum, '0);
    chk("midrst_flags", {busy, done, no_winner, timeout}, 4'b0);
    chk("midrst_win", {winner_idx, winner_val, iter_count}, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle", {busy, done}, 2'b0);
    run(tbl[1].d, 0, lat);
    check_model("postrst", tbl[1].d, lat);

    // Randomized vectors against the whole-run model.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 9))
          0:       d[k] = 32'h0;
          1:       d[k] = {1'b1, 8'd127, 23'($urandom)};
          2:       d[k] = 32'h80000000;
          default: d[k] = {1'b0, 8'($urandom_range(123, 126)), 23'($urandom)};
        endcase
      end
      run(d, r[0], lat);
      check_model($sformatf("rnd%0d", r), d, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/maxnet_iteration_controller.md
Name: maxnet_iteration_controller

Overview:
- Sequencer that sits on the other side of the four floating-point processing units (4-input weighted-sum, 2-register pipeline) in the Maxnet datapath.
- Holds the four neuron activations and drives them onto every PU's num inputs. Weight rows are wired externally: self weight 1.0, others -epsilon.
- Waits out the PU pipeline latency, captures the four PU results and applies ReLU. It repeats until at most one neuron is non-zero or an iteration cap is hit, then reports the winner.

Parameters:
XLEN, 32, float word width (IEEE-754 single at default)
PU_LATENCY, 2, clock edges from stable num inputs to valid PU result
MAX_ITER, 255, iteration cap before timeout
ITER_W, 8, width of iteration counter (must hold MAX_ITER)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE or DONE
data_in0..data_in3  in  XLEN each  initial activations, sampled on accepted start
pu_result0..pu_result3  in  XLEN each  result of PU k (neuron k's new value)
pu_num0..pu_num3  out  XLEN each  current activation k, fanned out to num_k of all four PUs
busy  out  1  high in WAIT/CAPTURE/CHECK
done  out  1  high while in DONE
winner_idx  out  2  index of surviving neuron
winner_val  out  XLEN  activation of winner
no_winner  out  1  all activations reached zero
timeout  out  1  MAX_ITER reached with >1 non-zero
iter_count  out  ITER_W  completed iterations

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE; V0..V3=0, so pu_num*=0; iter_count=0; wait counter=0; busy=0; done=0; winner_idx=0; winner_val=0; no_winner=0; timeout=0. Reset overrides all events, including mid-iteration. The pipeline contents of the PUs are ignored afterwards.
- ReLU(x): result is 0 if x[XLEN-1]==1 or x[XLEN-2:0]==0, else x. A value is non-zero iff ReLU(x)[XLEN-2:0]!=0. Negative zero counts as zero.
- pu_numk = Vk combinationally from registers at all times.
- IDLE, on start: Vk<=ReLU(data_ink); iter_count<=0; clear winner_idx, winner_val, no_winner and timeout; go to WAIT.
- WAIT: stays exactly PU_LATENCY cycles, with the counter counting 0..PU_LATENCY-1, then goes to CAPTURE. V is stable throughout.
- CAPTURE: one cycle. At the edge, Vk<=ReLU(pu_resultk) for all k and iter_count<=iter_count+1. Go to CHECK.
- CHECK: one cycle. nz = number of non-zero Vk.
  - nz==0: no_winner<=1, winner_idx<=0, winner_val<=0, go to DONE.
  - nz==1: winner_idx<=index of the non-zero neuron, winner_val<=its value, go to DONE.
  - nz>1 and iter_count==MAX_ITER: timeout<=1, winner_idx<=lowest non-zero index, winner_val<=its value, go to DONE.
  - Otherwise go to WAIT.
- Always at least one iteration runs, even if the loaded vector already has ≤1 non-zero.
- Timing per iteration: PU_LATENCY+2 cycles. done rises 1+N*(PU_LATENCY+2) cycles after the cycle in which start was sampled, for N iterations.
- DONE: outputs held. start here behaves exactly as in IDLE: it reloads and clears flags, and done falls the next cycle.
- start while busy is ignored with no side effects.
- iter_count saturates logically because CHECK exits at MAX_ITER, so it never wraps.
- done, timeout and no_winner are mutually consistent: timeout and no_winner are never both 1.

Test Plan:
- Winner case, epsilon=0.25, PUs with weights {1,-0.25,-0.25,-0.25} rotated. Inputs 0x3F000000 (0.5), 0x3ECCCCCD (0.4), 0x3E99999A (0.3), 0x3E4CCCCD (0.2) -> iterations leave n3=0, then n2=0, then n1=0 at iteration 4. Required: done high 17 cycles after start, iter_count=4, winner_idx=0, winner_val≈0.2082031 (±1 ulp), no_winner=0, timeout=0.
- Single positive input: 0.7 (0x3F333333), 0, 0, 0 -> iter_count=1, done after 5 cycles, winner_idx=0, winner_val=0x3F333333.
- Tie: all inputs 0.5 with MAX_ITER=8 -> no neuron ever drops out, so timeout=1, iter_count=8, winner_idx=0, done after 33 cycles.
- All negative: inputs -1.0 (0xBF800000) x4 -> ReLU at load gives zeros; after 1 iteration no_winner=1, winner_val=0, winner_idx=0.
- Protocol: pulse start during WAIT -> ignored, and the result is identical to an undisturbed run. Pulse start in DONE with new data -> done drops next cycle and the new run completes.
- Reset mid-operation: drive rst=0 for 1 cycle in CAPTURE -> next cycle state=IDLE, all outputs 0. A subsequent start runs correctly with no stale PU data captured.
